// File: rtl/mult_pkg.sv
// Shared widths and operand/product types for the 4x4 array multiplier.
package mult_pkg;
   localparam int unsigned WIDTH  = 4;
   localparam int unsigned PROD_W = 2 * WIDTH;

   typedef logic [WIDTH-1:0]  operand_t;
   typedef logic [PROD_W-1:0] product_t;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple rows of the array.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/multiplier_4bit_core.sv
// Unsigned 4x4 array multiplier with registered operands and product.
// Fixed two-stage pipeline that accepts a new pair every cycle.
module multiplier_4bit_core #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   output logic [2*WIDTH-1:0]   result
);
   import mult_pkg::*;

   operand_t r_a;
   operand_t r_b;
   logic     r_v;
   product_t r_result;
   logic     r_out_valid;

   logic [WIDTH-1:0] w_pp  [WIDTH];
   logic [WIDTH-1:0] w_x   [1:WIDTH-1];
   logic [WIDTH-1:0] w_sum [1:WIDTH-1];
   logic [WIDTH:0]   w_c   [1:WIDTH-1];
   product_t         w_prod;

   always_comb begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
         w_pp[i] = '0;
         for (int unsigned j = 0; j < WIDTH; j++) begin
            w_pp[i][j] = r_a[j] & r_b[i];
         end
      end
   end

   // Each row adds the next PP row to the upper bits of the previous row's
   // sum, with that row's carry-out feeding the top input position.
   genvar r, j;
   generate
      for (r = 1; r < WIDTH; r++) begin : g_row
         assign w_c[r][0] = 1'b0;
         if (r == 1) begin : g_first
            assign w_x[r] = {1'b0, w_pp[0][WIDTH-1:1]};
         end else begin : g_next
            assign w_x[r] = {w_c[r-1][WIDTH], w_sum[r-1][WIDTH-1:1]};
         end
         for (j = 0; j < WIDTH; j++) begin : g_col
            full_adder u_fa (
               .a    (w_x[r][j]),
               .b    (w_pp[r][j]),
               .cin  (w_c[r][j]),
               .sum  (w_sum[r][j]),
               .cout (w_c[r][j+1])
            );
         end
      end
   endgenerate

   always_comb begin
      w_prod    = '0;
      w_prod[0] = w_pp[0][0];
      for (int unsigned k = 1; k < WIDTH - 1; k++) begin
         w_prod[k] = w_sum[k][0];
      end
      w_prod[2*WIDTH-2 -: WIDTH] = w_sum[WIDTH-1];
      w_prod[2*WIDTH-1]          = w_c[WIDTH-1][WIDTH];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_v         <= 1'b0;
         r_result    <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_a         <= a;
         r_b         <= b;
         r_v         <= in_valid;
         r_result    <= w_prod;
         r_out_valid <= r_v;
      end
   end

   assign result    = r_result;
   assign out_valid = r_out_valid;
endmodule

// File: tb/tb_multiplier_4bit_core.sv
// Directed bench for multiplier_4bit_core: reset, corner products, streaming,
// mid-flight reset and a full 16x16 operand sweep.
module tb_multiplier_4bit_core;
   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic       out_valid;
   logic [7:0] result;

   int n_tests;
   int n_fail;

   logic [3:0] qa[$];
   logic [3:0] qb[$];

   multiplier_4bit_core #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] exp_res, input logic exp_v);
      n_tests++;
      assert (result === exp_res && out_valid === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s: result=%h out_valid=%b, expected result=%h out_valid=%b",
                tag, result, out_valid, exp_res, exp_v);
      end
   endtask

   // Presents the queued pairs on consecutive cycles; pair k is checked
   // one edge after the edge that captured it.
   task automatic run_stream(input string tag);
      int n;
      logic [7:0] e;
      n = qa.size();
      for (int k = 0; k <= n; k++) begin
         if (k < n) begin
            a = qa[k];
            b = qb[k];
            in_valid = 1'b1;
         end else begin
            a = 4'h0;
            b = 4'h0;
            in_valid = 1'b0;
         end
         step();
         if (k >= 1) begin
            e = 8'(int'(qa[k-1]) * int'(qb[k-1]));
            check($sformatf("%s[%0d] %0d*%0d", tag, k-1, qa[k-1], qb[k-1]), e, 1'b1);
         end
      end
      qa.delete();
      qb.delete();
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = 4'h0;
      b        = 4'h0;

      step();
      step();
      check("reset", 8'h00, 1'b0);
      rst_n = 1'b1;

      a = 4'hF; b = 4'hF; in_valid = 1'b1;
      step();
      a = 4'h0; b = 4'h0; in_valid = 1'b0;
      step();
      check("max 15*15", 8'hE1, 1'b1);
      step();
      check("idle after max", 8'h00, 1'b0);

      qa = '{4'd15, 4'd13, 4'd15, 4'd12};
      qb = '{4'd15, 4'd8,  4'd13, 4'd9};
      run_stream("b2b");

      qa = '{4'd0, 4'd1,  4'd11};
      qb = '{4'd9, 4'd11, 4'd1};
      run_stream("zero_id");

      a = 4'd3; b = 4'd5; in_valid = 1'b0;
      step();
      step();
      check("invalid data tracks", 8'd15, 1'b0);

      a = 4'd7; b = 4'd9; in_valid = 1'b1;
      step();
      rst_n = 1'b0; in_valid = 1'b0; a = 4'h0; b = 4'h0;
      step();
      check("midrst during", 8'h00, 1'b0);
      rst_n = 1'b1;
      step();
      check("midrst +1", 8'h00, 1'b0);
      step();
      check("midrst +2", 8'h00, 1'b0);

      a = 4'd6; b = 4'd7; in_valid = 1'b1;
      step();
      a = 4'h0; b = 4'h0; in_valid = 1'b0;
      step();
      check("post reset 6*7", 8'd42, 1'b1);

      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            qa.push_back(4'(i));
            qb.push_back(4'(j));
         end
      end
      run_stream("sweep");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
